// File: rtl/vga_timing_decoder_if.sv
// VGA receive-side bundle: sync/colour inputs from the controller and the
// recovered pixel stream plus timing status back out.
interface vga_timing_decoder_if;
   logic       i_HSYNC;
   logic       i_VSYNC;
   logic [3:0] i_RED;
   logic [3:0] i_GREEN;
   logic [3:0] i_BLUE;
   logic [9:0] o_X;
   logic [9:0] o_Y;
   logic [11:0] o_RGB;
   logic       o_PIXEL_VALID;
   logic       o_FRAME_START;
   logic       o_LOCKED;
   logic       o_HERR;
   logic       o_VERR;

   modport master (
      output i_HSYNC, i_VSYNC, i_RED, i_GREEN, i_BLUE,
      input  o_X, o_Y, o_RGB, o_PIXEL_VALID, o_FRAME_START, o_LOCKED, o_HERR, o_VERR
   );

   modport slave (
      input  i_HSYNC, i_VSYNC, i_RED, i_GREEN, i_BLUE,
      output o_X, o_Y, o_RGB, o_PIXEL_VALID, o_FRAME_START, o_LOCKED, o_HERR, o_VERR
   );
endinterface

// File: rtl/vga_timing_decoder.sv
// VGA timing decoder: recovers pixel coordinates from HSYNC/VSYNC, checks line
// and frame timing, and reports lock plus horizontal/vertical error pulses.
module vga_timing_decoder #(
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned H_FP     = 16,
   parameter int unsigned H_SYNC   = 96,
   parameter int unsigned H_BP     = 48,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned V_FP     = 10,
   parameter int unsigned V_SYNC   = 2,
   parameter int unsigned V_BP     = 33,
   parameter bit          SYNC_POL = 1'b0
) (
   input logic i_CLK,
   input logic i_RESET,
   vga_timing_decoder_if.slave vga
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
   localparam logic [9:0] H_TOT10 = 10'(H_TOTAL);
   localparam logic [9:0] H_SYN10 = 10'(H_SYNC);
   localparam logic [9:0] H_VIS0  = 10'(H_SYNC + H_BP);
   localparam logic [9:0] H_VIS1  = 10'(H_SYNC + H_BP + H_ACTIVE - 1);
   localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
   localparam logic [9:0] V_TOT10 = 10'(V_TOTAL);
   localparam logic [9:0] V_SYN10 = 10'(V_SYNC);
   localparam logic [9:0] V_VIS0  = 10'(V_SYNC + V_BP);
   localparam logic [9:0] V_VIS1  = 10'(V_SYNC + V_BP + V_ACTIVE - 1);

   typedef enum logic [1:0] {
      ST_UNLOCKED,
      ST_ACQUIRE,
      ST_LOCKED
   } state_t;

   state_t      state;
   logic        hs_r, vs_r, hs_d;
   logic [11:0] rgb_r;
   logic [9:0]  h_cnt, v_cnt;
   logic        h_seen, v_seen;
   logic        vs_line;

   logic        hs_on, hs_was, vs_on;
   logic        line_edge, hs_fall, v_start, v_end;
   logic [9:0]  h_cur, v_cur, h_inc, v_inc;
   logic [9:0]  x_cur, y_cur;
   logic        herr, verr, err, visible, valid_c;
   logic        h_seen_nx, v_seen_nx;

   // h_cur/v_cur are the counts belonging to the stage-1 pixel, so the old
   // register value is what is checked on an assertion edge and the new one elsewhere.
   always_comb begin
      hs_on     = (hs_r == SYNC_POL);
      hs_was    = (hs_d == SYNC_POL);
      vs_on     = (vs_r == SYNC_POL);
      line_edge = hs_on && !hs_was;
      hs_fall   = !hs_on && hs_was;
      v_start   = line_edge && vs_on && !vs_line;
      v_end     = line_edge && !vs_on && vs_line;

      h_inc = (h_cnt == '1) ? h_cnt : h_cnt + 10'd1;
      v_inc = (v_cnt == '1) ? v_cnt : v_cnt + 10'd1;
      h_cur = line_edge ? '0 : h_inc;
      v_cur = v_cnt;
      if (v_start)
         v_cur = '0;
      else if (line_edge)
         v_cur = v_inc;

      herr = h_seen && ((line_edge && (h_cnt != H_LAST)) ||
                        (hs_fall && (h_cur != H_SYN10)) ||
                        (!line_edge && (h_cur == H_TOT10)));
      verr = v_seen && ((v_start && (v_cnt != V_LAST)) ||
                        (v_end && (v_cur != V_SYN10)) ||
                        (line_edge && !v_start && (v_cur == V_TOT10)));
      err  = herr || verr;

      h_seen_nx = h_seen;
      if (line_edge)
         h_seen_nx = 1'b1;
      else if (h_cur == H_TOT10)
         h_seen_nx = 1'b0;

      v_seen_nx = v_seen;
      if (v_start)
         v_seen_nx = 1'b1;
      else if (line_edge && (v_cur == V_TOT10))
         v_seen_nx = 1'b0;

      visible = (h_cur >= H_VIS0) && (h_cur <= H_VIS1) &&
                (v_cur >= V_VIS0) && (v_cur <= V_VIS1);
      valid_c = visible && (state == ST_LOCKED);
      x_cur   = h_cur - H_VIS0;
      y_cur   = v_cur - V_VIS0;
   end

   always_ff @(posedge i_CLK or posedge i_RESET) begin
      if (i_RESET) begin
         state             <= ST_UNLOCKED;
         hs_r              <= ~SYNC_POL;
         vs_r              <= ~SYNC_POL;
         hs_d              <= ~SYNC_POL;
         rgb_r             <= '0;
         h_cnt             <= '0;
         v_cnt             <= '0;
         h_seen            <= 1'b0;
         v_seen            <= 1'b0;
         vs_line           <= 1'b0;
         vga.o_X           <= '0;
         vga.o_Y           <= '0;
         vga.o_RGB         <= '0;
         vga.o_PIXEL_VALID <= 1'b0;
         vga.o_FRAME_START <= 1'b0;
         vga.o_LOCKED      <= 1'b0;
         vga.o_HERR        <= 1'b0;
         vga.o_VERR        <= 1'b0;
      end else begin
         hs_r   <= vga.i_HSYNC;
         vs_r   <= vga.i_VSYNC;
         hs_d   <= hs_r;
         rgb_r  <= {vga.i_RED, vga.i_GREEN, vga.i_BLUE};
         h_cnt  <= h_cur;
         v_cnt  <= v_cur;
         h_seen <= h_seen_nx;
         v_seen <= v_seen_nx;
         if (line_edge)
            vs_line <= vs_on;

         // An error always wins over a coincident vsync start.
         case (state)
            ST_UNLOCKED: if (v_start && !err) state <= ST_ACQUIRE;
            ST_ACQUIRE: begin
               if (err)
                  state <= ST_UNLOCKED;
               else if (v_start)
                  state <= ST_LOCKED;
            end
            ST_LOCKED:   if (err) state <= ST_UNLOCKED;
            default:     state <= ST_UNLOCKED;
         endcase

         vga.o_X           <= valid_c ? x_cur : '0;
         vga.o_Y           <= valid_c ? y_cur : '0;
         vga.o_RGB         <= valid_c ? rgb_r : '0;
         vga.o_PIXEL_VALID <= valid_c;
         vga.o_FRAME_START <= valid_c && (x_cur == '0) && (y_cur == '0);
         vga.o_LOCKED      <= (state == ST_LOCKED);
         vga.o_HERR        <= herr;
         vga.o_VERR        <= verr;
      end
   end

endmodule

// File: tb/tb_vga_timing_decoder.sv
// Directed bench for vga_timing_decoder using a scaled-down timing set so
// whole frames fit in a short run; expectations derive from the bench's own generator.
module tb_vga_timing_decoder;

   localparam int H_ACTIVE = 16;
   localparam int H_FP     = 2;
   localparam int H_SYNC   = 4;
   localparam int H_BP     = 3;
   localparam int V_ACTIVE = 8;
   localparam int V_FP     = 2;
   localparam int V_SYNC   = 2;
   localparam int V_BP     = 3;
   localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HV0      = H_SYNC + H_BP;
   localparam int VV0      = V_SYNC + V_BP;
   localparam int FRAME_PIX = H_ACTIVE * V_ACTIVE;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   vga_timing_decoder_if vif();

   vga_timing_decoder #(
      .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
      .SYNC_POL(1'b0)
   ) dut (
      .i_CLK(clk),
      .i_RESET(rst),
      .vga(vif)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got == exp)
         n_pass++;
      else
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   // generator state for the pixel currently on the inputs
   int          gen_line = 0, gen_h = 0;
   logic        gen_vis = 1'b0;
   logic [9:0]  gen_x = '0, gen_y = '0;
   logic [11:0] gen_rgb = '0;

   // monitor: running totals, read as deltas by the main sequence
   int valid_tot = 0, fs_tot = 0, herr_tot = 0, verr_tot = 0, mism_tot = 0;
   int rise_tot = 0, rise_line = 0, rise_h = 0, fall_line = 0, fall_h = 0;
   int herr_l [8], herr_p [8], verr_l [8], verr_p [8];
   logic        lock_q = 1'b0;
   logic        hvis0 = 1'b0, hvis1 = 1'b0;
   logic [9:0]  hx0 = '0, hx1 = '0, hy0 = '0, hy1 = '0;
   logic [11:0] hr0 = '0, hr1 = '0;

   always @(negedge clk) begin
      if (vif.o_PIXEL_VALID) begin
         valid_tot <= valid_tot + 1;
         if (!hvis1 || vif.o_X != hx1 || vif.o_Y != hy1 || vif.o_RGB != hr1)
            mism_tot <= mism_tot + 1;
      end else if (vif.o_X != '0 || vif.o_Y != '0 || vif.o_RGB != '0) begin
         mism_tot <= mism_tot + 1;
      end
      if (vif.o_FRAME_START != (vif.o_PIXEL_VALID && hvis1 && hx1 == '0 && hy1 == '0))
         mism_tot <= mism_tot + 1;
      if (vif.o_FRAME_START) fs_tot <= fs_tot + 1;
      if (vif.o_HERR) begin
         herr_l[herr_tot % 8] <= gen_line;
         herr_p[herr_tot % 8] <= gen_h;
         herr_tot <= herr_tot + 1;
      end
      if (vif.o_VERR) begin
         verr_l[verr_tot % 8] <= gen_line;
         verr_p[verr_tot % 8] <= gen_h;
         verr_tot <= verr_tot + 1;
      end
      if (vif.o_LOCKED && !lock_q) begin
         rise_tot  <= rise_tot + 1;
         rise_line <= gen_line;
         rise_h    <= gen_h;
      end
      if (!vif.o_LOCKED && lock_q) begin
         fall_line <= gen_line;
         fall_h    <= gen_h;
      end
      lock_q <= vif.o_LOCKED;
      hvis1 <= hvis0; hx1 <= hx0; hy1 <= hy0; hr1 <= hr0;
      hvis0 <= gen_vis; hx0 <= gen_x; hy0 <= gen_y; hr0 <= gen_rgb;
   end

   int s_valid, s_fs, s_herr, s_verr, s_mism, s_rise;
   int d_valid, d_fs, d_herr, d_verr, d_mism, d_rise;

   // One frame of lines; -1 disables the short/long line and reset injection.
   task automatic run_frame(input int vs_w, input int n_lines,
                            input int short_at, input int short_len,
                            input int long_at, input int long_len,
                            input int rst_line, input int rst_h);
      s_valid = valid_tot; s_fs = fs_tot; s_herr = herr_tot;
      s_verr = verr_tot; s_mism = mism_tot; s_rise = rise_tot;
      for (int l = 0; l < n_lines; l++) begin
         int len;
         len = (l == short_at) ? short_len : (l == long_at) ? long_len : H_TOTAL;
         for (int h = 0; h < len; h++) begin
            @(posedge clk);
            #1;
            rst = 1'b0;
            gen_line = l;
            gen_h    = h;
            vif.i_HSYNC = (h < H_SYNC) ? 1'b0 : 1'b1;
            vif.i_VSYNC = (l < vs_w) ? 1'b0 : 1'b1;
            gen_vis = (h >= HV0) && (h < HV0 + H_ACTIVE) && (l >= VV0) && (l < VV0 + V_ACTIVE);
            gen_x   = gen_vis ? 10'(h - HV0) : '0;
            gen_y   = gen_vis ? 10'(l - VV0) : '0;
            gen_rgb = gen_vis ? {gen_x[3:0], gen_y[3:0], gen_x[7:4]} : 12'hFFF;
            {vif.i_RED, vif.i_GREEN, vif.i_BLUE} = gen_rgb;
            if (l == rst_line && h == rst_h) begin
               check("pre_rst_valid", int'(vif.o_PIXEL_VALID), 1);
               rst = 1'b1;
               #1;
               check("async_rst_valid", int'(vif.o_PIXEL_VALID), 0);
               check("async_rst_locked", int'(vif.o_LOCKED), 0);
               check("async_rst_xy", int'({vif.o_X, vif.o_Y}), 0);
               check("async_rst_rgb", int'(vif.o_RGB), 0);
            end
         end
      end
      d_valid = valid_tot - s_valid; d_fs = fs_tot - s_fs; d_herr = herr_tot - s_herr;
      d_verr = verr_tot - s_verr; d_mism = mism_tot - s_mism; d_rise = rise_tot - s_rise;
   endtask

   task automatic clean_frame();
      run_frame(V_SYNC, V_TOTAL, -1, 0, -1, 0, -1, -1);
   endtask

   task automatic check_locked_frame(input string tag);
      check({tag, "_valid"}, d_valid, FRAME_PIX);
      check({tag, "_fs"}, d_fs, 1);
      check({tag, "_mism"}, d_mism, 0);
      check({tag, "_herr"}, d_herr, 0);
      check({tag, "_verr"}, d_verr, 0);
   endtask

   task automatic check_relock(input string tag);
      clean_frame();
      check({tag, "_acq_valid"}, d_valid, 0);
      check({tag, "_acq_rise"}, d_rise, 0);
      check({tag, "_acq_err"}, d_herr + d_verr, 0);
      clean_frame();
      check({tag, "_rise"}, d_rise, 1);
      check({tag, "_rise_pos"}, rise_line * 1000 + rise_h, 3);
      check_locked_frame(tag);
   endtask

   initial begin
      vif.i_HSYNC = 1'b1;
      vif.i_VSYNC = 1'b1;
      {vif.i_RED, vif.i_GREEN, vif.i_BLUE} = '0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_locked", int'(vif.o_LOCKED), 0);
      check("rst_valid", int'(vif.o_PIXEL_VALID), 0);
      check("rst_err", int'({vif.o_HERR, vif.o_VERR, vif.o_FRAME_START}), 0);
      check("rst_xy", int'({vif.o_X, vif.o_Y}), 0);
      check("rst_rgb", int'(vif.o_RGB), 0);
      rst = 1'b0;

      // acquire on first vsync start, lock on the second
      clean_frame();
      check("f1_valid", d_valid, 0);
      check("f1_rise", d_rise, 0);
      check("f1_err", d_herr + d_verr, 0);
      clean_frame();
      check("f2_rise", d_rise, 1);
      check("f2_rise_pos", rise_line * 1000 + rise_h, 3);
      check_locked_frame("f2");
      clean_frame();
      check_locked_frame("f3");

      // one line of H_TOTAL-1 clocks
      run_frame(V_SYNC, V_TOTAL, 6, H_TOTAL - 1, -1, 0, -1, -1);
      check("short_herr", d_herr, 1);
      check("short_herr_pos", herr_l[s_herr % 8] * 1000 + herr_p[s_herr % 8], 7002);
      check("short_fall_pos", fall_line * 1000 + fall_h, 7003);
      check("short_valid", d_valid, 2 * H_ACTIVE);
      check("short_verr", d_verr, 0);
      check_relock("short_relock");

      // hsync held deasserted past the counter saturation point
      run_frame(V_SYNC, V_TOTAL, -1, 0, 3, 1100, -1, -1);
      check("long_herr", d_herr, 1);
      check("long_herr_pos", herr_l[s_herr % 8] * 1000 + herr_p[s_herr % 8], 3000 + H_TOTAL + 2);
      check("long_verr", d_verr, 0);
      check("long_valid", d_valid, 0);
      check_relock("long_relock");

      // short frame, then a 3-line vsync
      run_frame(V_SYNC, V_TOTAL - 1, -1, 0, -1, 0, -1, -1);
      check("vshort_verr", d_verr, 0);
      check("vshort_valid", d_valid, FRAME_PIX);
      run_frame(V_SYNC + 1, V_TOTAL, -1, 0, -1, 0, -1, -1);
      check("vwide_verr", d_verr, 2);
      check("vwide_verr0_pos", verr_l[s_verr % 8] * 1000 + verr_p[s_verr % 8], 2);
      check("vwide_verr1_pos", verr_l[(s_verr + 1) % 8] * 1000 + verr_p[(s_verr + 1) % 8], 3002);
      check("vwide_valid", d_valid, 0);
      check("vwide_herr", d_herr, 0);
      check_relock("vwide_relock");

      // asynchronous reset mid-line at x=10, y=5
      run_frame(V_SYNC, V_TOTAL, -1, 0, -1, 0, VV0 + 5, HV0 + 10);
      check("rst_mid_herr", d_herr, 0);
      check("rst_mid_verr", d_verr, 0);
      check("rst_mid_mism", d_mism, 0);
      check_relock("rst_relock");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
